// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: FSM states and redirect source codes.
package fetch_ctrl_pkg;

    // Fetch FSM state encodings
    localparam logic [1:0] FETCH_BOOT = 2'd0;
    localparam logic [1:0] FETCH_REQ  = 2'd1;
    localparam logic [1:0] FETCH_HOLD = 2'd2;

    // Redirect sources, numerically ordered so that a larger code wins
    localparam logic [1:0] REDIR_NONE = 2'd0;
    localparam logic [1:0] REDIR_JAL  = 2'd1;
    localparam logic [1:0] REDIR_BR   = 2'd2;
    localparam logic [1:0] REDIR_TRAP = 2'd3;

    typedef logic [1:0] redir_src_t;

    // A redirect target is misaligned when either of its two low bits is set
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return |low_bits;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_ctrl_redirect_arbiter.sv
// Picks the single redirect to honour this cycle from the new requests and the pending entry.
module fetch_ctrl_redirect_arbiter
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_target,
    input  logic            pend_valid,
    input  redir_src_t      pend_src,
    input  logic [XLEN-1:0] pend_target,
    output logic            win_valid,
    output redir_src_t      win_src,
    output logic [XLEN-1:0] win_target
);

    redir_src_t      new_src_s;
    logic [XLEN-1:0] new_target_s;

    // Fixed-priority pick among this cycle's new redirects: trap > branch > jump
    always_comb begin
        new_src_s    = REDIR_NONE;
        new_target_s = {XLEN{1'b0}};
        if (trap_valid) begin
            new_src_s    = REDIR_TRAP;
            new_target_s = trap_target;
        end else if (br_valid) begin
            new_src_s    = REDIR_BR;
            new_target_s = br_target;
        end else if (jal_valid) begin
            new_src_s    = REDIR_JAL;
            new_target_s = jal_target;
        end else begin
            new_src_s    = REDIR_NONE;
            new_target_s = {XLEN{1'b0}};
        end
    end

    // A new redirect displaces the pending one only when it is at least as important
    always_comb begin
        win_valid  = 1'b0;
        win_src    = REDIR_NONE;
        win_target = {XLEN{1'b0}};
        if ((new_src_s != REDIR_NONE) && (!pend_valid || (new_src_s >= pend_src))) begin
            win_valid  = 1'b1;
            win_src    = new_src_s;
            win_target = new_target_s;
        end else if (pend_valid) begin
            win_valid  = 1'b1;
            win_src    = pend_src;
            win_target = pend_target;
        end else begin
            win_valid  = 1'b0;
            win_src    = REDIR_NONE;
            win_target = {XLEN{1'b0}};
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC update controls, owns the imem handshake, buffers one
// instruction while decode stalls and squashes fetches made stale by a redirect.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_in,
    fetch_ctrl_if.master    imem,
    input  logic            id_stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            jal_valid,
    input  logic [XLEN-1:0] jal_target,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            pc_write_enable,
    output logic            pc_sel,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if,
    output logic            misalign_err
);

    logic [1:0]      state_q, state_d;
    logic            pend_valid_q, pend_valid_d;
    redir_src_t      pend_src_q, pend_src_d;
    logic [XLEN-1:0] pend_target_q, pend_target_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic            win_valid_s;
    redir_src_t      win_src_s;
    logic [XLEN-1:0] win_target_s;

    logic            req_s;
    logic            apply_s;
    logic            if_valid_s;
    logic [31:0]     if_instr_s;
    logic [XLEN-1:0] if_pc_s;
    logic            pwe_s;
    logic            sel_s;

    fetch_ctrl_redirect_arbiter #(.XLEN(XLEN)) u_arb (
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .jal_valid   (jal_valid),
        .jal_target  (jal_target),
        .pend_valid  (pend_valid_q),
        .pend_src    (pend_src_q),
        .pend_target (pend_target_q),
        .win_valid   (win_valid_s),
        .win_src     (win_src_s),
        .win_target  (win_target_s)
    );

    // Next-state, pending-redirect, hold-buffer and per-cycle control decisions
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_src_d    = pend_src_q;
        pend_target_d = pend_target_q;
        hold_instr_d  = hold_instr_q;
        hold_pc_d     = hold_pc_q;
        req_s         = 1'b0;
        apply_s       = 1'b0;
        if_valid_s    = 1'b0;
        if_instr_s    = 32'd0;
        if_pc_s       = pc_in;
        pwe_s         = 1'b0;
        sel_s         = 1'b0;
        case (state_q)
            FETCH_BOOT: begin
                // Quiet cycle; redirects seen now are remembered for the first fetch
                if_pc_s       = RESET_VECTOR;
                pend_valid_d  = win_valid_s;
                pend_src_d    = win_src_s;
                pend_target_d = win_target_s;
                state_d       = FETCH_REQ;
            end
            FETCH_REQ: begin
                req_s = 1'b1;
                if (imem.imem_ack) begin
                    pwe_s = 1'b1;
                    if (win_valid_s) begin
                        // Returned word is stale: drop it and steer the PC
                        apply_s      = 1'b1;
                        sel_s        = 1'b1;
                        pend_valid_d = 1'b0;
                        pend_src_d   = REDIR_NONE;
                    end else if (!id_stall) begin
                        if_valid_s = 1'b1;
                        if_instr_s = imem.imem_rdata;
                    end else begin
                        hold_instr_d = imem.imem_rdata;
                        hold_pc_d    = pc_in;
                        state_d      = FETCH_HOLD;
                    end
                end else begin
                    // Request in flight: keep it up, queue the redirect for the ack
                    pend_valid_d  = win_valid_s;
                    pend_src_d    = win_src_s;
                    pend_target_d = win_target_s;
                end
            end
            FETCH_HOLD: begin
                if_pc_s = hold_pc_q;
                if (win_valid_s) begin
                    apply_s      = 1'b1;
                    pwe_s        = 1'b1;
                    sel_s        = 1'b1;
                    pend_valid_d = 1'b0;
                    pend_src_d   = REDIR_NONE;
                    state_d      = FETCH_REQ;
                end else begin
                    if_valid_s = 1'b1;
                    if_instr_s = hold_instr_q;
                    if (!id_stall) begin
                        state_d = FETCH_REQ;
                    end else begin
                        state_d = FETCH_HOLD;
                    end
                end
            end
            default: begin
                state_d      = FETCH_BOOT;
                pend_valid_d = 1'b0;
                pend_src_d   = REDIR_NONE;
            end
        endcase
    end

    // Output drive; address and redirect fields read as zero when not in use
    always_comb begin
        imem.imem_req   = req_s;
        imem.imem_addr  = req_s ? pc_in : {XLEN{1'b0}};
        if_valid        = if_valid_s;
        if_instr        = if_instr_s;
        if_pc           = if_pc_s;
        pc_write_enable = pwe_s;
        pc_sel          = sel_s;
        flush_if        = apply_s;
        redirect_pc     = apply_s ? {win_target_s[XLEN-1:2], 2'b00} : {XLEN{1'b0}};
        misalign_err    = apply_s & is_misaligned(win_target_s[1:0]);
    end

    // State, pending redirect and hold buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FETCH_BOOT;
            pend_valid_q  <= 1'b0;
            pend_src_q    <= REDIR_NONE;
            pend_target_q <= {XLEN{1'b0}};
            hold_instr_q  <= 32'd0;
            hold_pc_q     <= {XLEN{1'b0}};
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_src_q    <= pend_src_d;
            pend_target_q <= pend_target_d;
            hold_instr_q  <= hold_instr_d;
            hold_pc_q     <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: each cycle's expected outputs are queued when the
// stimulus is driven and popped/compared at the following falling clock edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_reg;
    logic        id_stall = 1'b0;
    logic        trap_valid = 1'b0, br_valid = 1'b0, jal_valid = 1'b0;
    logic [31:0] trap_target = 32'd0, br_target = 32'd0, jal_target = 32'd0;
    logic        if_valid, pc_write_enable, pc_sel, flush_if, misalign_err;
    logic [31:0] if_instr, if_pc, redirect_pc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ifpc;
        logic        pwe;
        logic        sel;
        logic [31:0] rpc;
        logic        flush;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];

    fetch_ctrl_if #(.XLEN(32)) imem_bus ();

    fetch_ctrl #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_in           (pc_reg),
        .imem            (imem_bus),
        .id_stall        (id_stall),
        .trap_valid      (trap_valid),
        .trap_target     (trap_target),
        .br_valid        (br_valid),
        .br_target       (br_target),
        .jal_valid       (jal_valid),
        .jal_target      (jal_target),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .pc_write_enable (pc_write_enable),
        .pc_sel          (pc_sel),
        .redirect_pc     (redirect_pc),
        .flush_if        (flush_if),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    // Environment model of the PC register the sequencer controls
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_reg <= 32'd0;
        else if (pc_write_enable) pc_reg <= pc_sel ? redirect_pc : pc_reg + 32'd4;
    end

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'd0;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic expect_out(input logic req, input logic [31:0] addr, input logic valid,
                              input logic [31:0] instr, input logic [31:0] ifpc, input logic pwe,
                              input logic sel, input logic [31:0] rpc, input logic flush,
                              input logic mis);
        exp_t e;
        e.req = req; e.addr = addr; e.valid = valid; e.instr = instr; e.ifpc = ifpc;
        e.pwe = pwe; e.sel = sel; e.rpc = rpc; e.flush = flush; e.mis = mis;
        exp_q.push_back(e);
    endtask

    task automatic compare_now(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_val({tag, ".queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, ".imem_req"},  {31'd0, imem_bus.imem_req}, {31'd0, e.req});
            check_val({tag, ".imem_addr"}, imem_bus.imem_addr, e.addr);
            check_val({tag, ".if_valid"},  {31'd0, if_valid}, {31'd0, e.valid});
            check_val({tag, ".if_instr"},  if_instr, e.instr);
            check_val({tag, ".if_pc"},     if_pc, e.ifpc);
            check_val({tag, ".pc_we"},     {31'd0, pc_write_enable}, {31'd0, e.pwe});
            check_val({tag, ".pc_sel"},    {31'd0, pc_sel}, {31'd0, e.sel});
            check_val({tag, ".redir_pc"},  redirect_pc, e.rpc);
            check_val({tag, ".flush_if"},  {31'd0, flush_if}, {31'd0, e.flush});
            check_val({tag, ".misalign"},  {31'd0, misalign_err}, {31'd0, e.mis});
        end
    endtask

    // Compare at the falling edge, then advance past the next rising edge and idle the inputs
    task automatic run_cycle(input string tag);
        @(negedge clk);
        compare_now(tag);
        @(posedge clk);
        #1;
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        trap_valid = 1'b0; br_valid = 1'b0; jal_valid = 1'b0;
        trap_target = 32'd0; br_target = 32'd0; jal_target = 32'd0;
    endtask

    task automatic ack(input logic [31:0] rdata);
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = rdata;
    endtask

    initial begin
        #3;
        expect_out(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
        compare_now("in_reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot: one quiet cycle, then fetch from pc 0
        expect_out(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
        run_cycle("boot");
        expect_out(1, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
        run_cycle("first_req");
        ack(32'h00500093);
        expect_out(1, 32'h0, 1, 32'h00500093, 32'h0, 1, 0, 32'h0, 0, 0);
        run_cycle("first_ack");

        // Decode stall: instruction parks in the hold buffer
        ack(32'h00A00113); id_stall = 1'b1;
        expect_out(1, 32'h4, 0, 32'h0, 32'h4, 1, 0, 32'h0, 0, 0);
        run_cycle("stall_ack");
        for (int i = 0; i < 3; i++) begin
            expect_out(0, 32'h0, 1, 32'h00A00113, 32'h4, 0, 0, 32'h0, 0, 0);
            run_cycle("hold");
        end
        id_stall = 1'b0;
        expect_out(0, 32'h0, 1, 32'h00A00113, 32'h4, 0, 0, 32'h0, 0, 0);
        run_cycle("hold_consume");
        expect_out(1, 32'h8, 0, 32'h0, 32'h8, 0, 0, 32'h0, 0, 0);
        run_cycle("req_after_hold");

        // Branch while a request is outstanding: applied on the ack
        br_valid = 1'b1; br_target = 32'h100;
        expect_out(1, 32'h8, 0, 32'h0, 32'h8, 0, 0, 32'h0, 0, 0);
        run_cycle("br_pending");
        expect_out(1, 32'h8, 0, 32'h0, 32'h8, 0, 0, 32'h0, 0, 0);
        run_cycle("br_wait");
        ack(32'hDEADBEEF);
        expect_out(1, 32'h8, 0, 32'h0, 32'h8, 1, 1, 32'h100, 1, 0);
        run_cycle("br_apply");
        expect_out(1, 32'h100, 0, 32'h0, 32'h100, 0, 0, 32'h0, 0, 0);
        run_cycle("req_at_0x100");

        // Same-cycle trap beats branch
        ack(32'h12345678);
        trap_valid = 1'b1; trap_target = 32'h80; br_valid = 1'b1; br_target = 32'h100;
        expect_out(1, 32'h100, 0, 32'h0, 32'h100, 1, 1, 32'h80, 1, 0);
        run_cycle("trap_vs_br");

        // Pending jal displaced by a later branch
        jal_valid = 1'b1; jal_target = 32'h40;
        expect_out(1, 32'h80, 0, 32'h0, 32'h80, 0, 0, 32'h0, 0, 0);
        run_cycle("pend_jal");
        br_valid = 1'b1; br_target = 32'h200;
        expect_out(1, 32'h80, 0, 32'h0, 32'h80, 0, 0, 32'h0, 0, 0);
        run_cycle("pend_br");
        ack(32'h0);
        expect_out(1, 32'h80, 0, 32'h0, 32'h80, 1, 1, 32'h200, 1, 0);
        run_cycle("apply_br_over_jal");

        // Pending trap survives a later jal
        trap_valid = 1'b1; trap_target = 32'h80;
        expect_out(1, 32'h200, 0, 32'h0, 32'h200, 0, 0, 32'h0, 0, 0);
        run_cycle("pend_trap");
        jal_valid = 1'b1; jal_target = 32'h40;
        expect_out(1, 32'h200, 0, 32'h0, 32'h200, 0, 0, 32'h0, 0, 0);
        run_cycle("jal_dropped");
        ack(32'h0);
        expect_out(1, 32'h200, 0, 32'h0, 32'h200, 1, 1, 32'h80, 1, 0);
        run_cycle("apply_trap_over_jal");

        // Redirect while holding: applied at once, aligned target
        ack(32'h11111111); id_stall = 1'b1;
        expect_out(1, 32'h80, 0, 32'h0, 32'h80, 1, 0, 32'h0, 0, 0);
        run_cycle("hold_enter_a");
        br_valid = 1'b1; br_target = 32'h104;
        expect_out(0, 32'h0, 0, 32'h0, 32'h80, 1, 1, 32'h104, 1, 0);
        run_cycle("hold_redirect");

        // Redirect while holding: misaligned target gets cleared and flagged
        ack(32'h22222222);
        expect_out(1, 32'h104, 0, 32'h0, 32'h104, 1, 0, 32'h0, 0, 0);
        run_cycle("hold_enter_b");
        trap_valid = 1'b1; trap_target = 32'h106;
        expect_out(0, 32'h0, 0, 32'h0, 32'h104, 1, 1, 32'h104, 1, 1);
        run_cycle("misaligned_redirect");

        // Build a pending redirect, then reset asynchronously
        ack(32'h33333333);
        expect_out(1, 32'h104, 0, 32'h0, 32'h104, 1, 0, 32'h0, 0, 0);
        run_cycle("hold_enter_c");
        id_stall = 1'b0;
        expect_out(0, 32'h0, 1, 32'h33333333, 32'h104, 0, 0, 32'h0, 0, 0);
        run_cycle("hold_consume_c");
        br_valid = 1'b1; br_target = 32'h300;
        expect_out(1, 32'h108, 0, 32'h0, 32'h108, 0, 0, 32'h0, 0, 0);
        run_cycle("pend_before_reset");
        trap_valid = 1'b1; trap_target = 32'h80;
        #2 rst_n = 1'b0;
        #1;
        expect_out(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
        compare_now("async_reset");
        trap_valid = 1'b0; trap_target = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Boot repeats; the first ack must not carry the pre-reset branch
        expect_out(0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0);
        run_cycle("reboot");
        ack(32'h44444444);
        expect_out(1, 32'h0, 1, 32'h44444444, 32'h0, 1, 0, 32'h0, 0, 0);
        run_cycle("reboot_fetch");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound the run in case the sequence stalls
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
